// File: rtl/fp32_pkg.sv
// fp32_pkg: shared binary32 field widths, special encodings and the packed
// operand view used by the floating-point adder.
package fp32_pkg;

    localparam int          EXP_W   = 8;
    localparam int          FRAC_W  = 23;
    localparam int          BIAS    = 127;
    localparam logic [7:0]  EXP_MAX = 8'hFF;
    localparam logic [31:0] QNAN    = 32'h7FC00000;

    typedef struct packed {
        logic              sign;
        logic [EXP_W-1:0]  exp;
        logic [FRAC_W-1:0] frac;
    } fp32_t;

endpackage

// File: rtl/fp_lzc27.sv
// fp_lzc27: combinational leading-zero counter for the adder's normalize
// vector {carry, hidden, frac, G, R}.
// Ports:
//   vec   : 27-bit vector to scan, MSB first
//   count : number of leading zeros (27 when vec is all zero)
module fp_lzc27 (
    input  logic [26:0] vec,
    output logic [4:0]  count
);

    // Ascending scan: the highest set bit is the last one written.
    always_comb begin
        count = 5'd27;
        for (int i = 0; i < 27; i++) begin
            if (vec[i]) begin
                count = 5'(26 - i);
            end
        end
    end

endmodule

// File: rtl/fp_adderz.sv
// fp_adderz: IEEE-754 binary32 adder, round to nearest even, with gradual
// underflow. Combinational datapath feeding one output register.
// Ports:
//   clk   : system clock, rising edge
//   rst_n : asynchronous reset, active low; clears s
//   a, b  : binary32 operands, sampled every clock
//   s     : registered sum, one cycle after the operands
module fp_adderz
    import fp32_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] s
);

    fp32_t       op_a;
    fp32_t       op_b;
    fp32_t       op_big;
    fp32_t       op_small;
    logic        swap;

    assign op_a = a;
    assign op_b = b;

    // Magnitude order: {exp, frac} compares as an unsigned integer.
    assign swap     = {op_b.exp, op_b.frac} > {op_a.exp, op_a.frac};
    assign op_big   = swap ? op_b : op_a;
    assign op_small = swap ? op_a : op_b;

    // ---------------- unpack ----------------
    logic [7:0]  e_big;
    logic [7:0]  e_small;
    logic [23:0] m_big;
    logic [23:0] m_small;

    assign e_big   = (op_big.exp == 8'd0)   ? 8'd1 : op_big.exp;
    assign e_small = (op_small.exp == 8'd0) ? 8'd1 : op_small.exp;
    assign m_big   = {(op_big.exp != 8'd0),   op_big.frac};
    assign m_small = {(op_small.exp != 8'd0), op_small.frac};

    // ---------------- align ----------------
    logic [7:0]  diff;
    logic [49:0] shift_vec;
    logic [25:0] small_gr;
    logic        small_sticky;

    assign diff      = e_big - e_small;
    // Significand placed above 26 spare bits so a shift of up to 25 loses
    // nothing; the low 24 bits collapse into sticky.
    assign shift_vec = {m_small, 26'd0} >> diff;

    always_comb begin
        if (diff >= 8'd26) begin
            small_gr     = 26'd0;
            small_sticky = |m_small;
        end else begin
            small_gr     = shift_vec[49:24];
            small_sticky = |shift_vec[23:0];
        end
    end

    // ---------------- add / subtract ----------------
    // Layout: [27] carry, [26:3] significand, [2] G, [1] R, [0] S.
    // Subtracting the sticky as a unit LSB keeps bits [27:1] exact and bit 0
    // a correct "nonzero remainder" flag.
    logic        eff_sub;
    logic [26:0] big_x;
    logic [26:0] small_x;
    logic [27:0] sum;

    assign eff_sub = op_a.sign ^ op_b.sign;
    assign big_x   = {m_big, 3'b000};
    assign small_x = {small_gr, small_sticky};
    assign sum     = eff_sub ? ({1'b0, big_x} - {1'b0, small_x})
                             : ({1'b0, big_x} + {1'b0, small_x});

    // ---------------- normalize ----------------
    logic [4:0]  lz;
    logic [7:0]  lz_m1;
    logic [7:0]  limit;
    logic [7:0]  sh;
    logic [26:0] shifted;
    logic [23:0] sig_norm;
    logic        g_bit;
    logic        r_bit;
    logic        s_bit;
    logic [8:0]  exp_norm;
    logic [8:0]  exp_field;

    fp_lzc27 u_lzc (
        .vec   (sum[27:1]),
        .count (lz)
    );

    always_comb begin
        lz_m1   = {3'b000, lz} - 8'd1;
        limit   = e_big - 8'd1;
        sh      = 8'd0;
        shifted = sum[26:0];
        if (sum[27]) begin
            sig_norm = sum[27:4];
            g_bit    = sum[3];
            r_bit    = sum[2];
            s_bit    = sum[1] | sum[0];
            exp_norm = {1'b0, e_big} + 9'd1;
        end else begin
            // Never drive the exponent below 1: leftover leading zeros
            // become a subnormal result.
            sh       = (lz_m1 > limit) ? limit : lz_m1;
            shifted  = sum[26:0] << sh;
            sig_norm = shifted[26:3];
            g_bit    = shifted[2];
            r_bit    = shifted[1];
            s_bit    = shifted[0];
            exp_norm = {1'b0, e_big} - {1'b0, sh};
        end
        // No hidden bit means subnormal encoding.
        exp_field = sig_norm[23] ? exp_norm : 9'd0;
    end

    // ---------------- round ----------------
    // Rounding increments the packed {exp, frac}; a fraction carry then
    // ripples into the exponent, covering subnormal->normal and binade bumps.
    logic        round_inc;
    logic [31:0] packed_r;
    logic        overflow;
    logic [31:0] finite_res;

    assign round_inc = g_bit & (r_bit | s_bit | sig_norm[0]);
    assign packed_r  = {exp_field, sig_norm[22:0]} + {31'd0, round_inc};
    assign overflow  = packed_r[31:23] >= 9'd255;

    always_comb begin
        if (sum == 28'd0) begin
            finite_res = 32'h0000_0000;
        end else if (overflow) begin
            finite_res = {op_big.sign, EXP_MAX, 23'd0};
        end else begin
            finite_res = {op_big.sign, packed_r[30:0]};
        end
    end

    // ---------------- special cases ----------------
    logic        a_nan;
    logic        b_nan;
    logic        a_inf;
    logic        b_inf;
    logic        a_zero;
    logic        b_zero;
    logic [31:0] sum_next;

    assign a_nan  = (op_a.exp == EXP_MAX) && (op_a.frac != 23'd0);
    assign b_nan  = (op_b.exp == EXP_MAX) && (op_b.frac != 23'd0);
    assign a_inf  = (op_a.exp == EXP_MAX) && (op_a.frac == 23'd0);
    assign b_inf  = (op_b.exp == EXP_MAX) && (op_b.frac == 23'd0);
    assign a_zero = (op_a.exp == 8'd0) && (op_a.frac == 23'd0);
    assign b_zero = (op_b.exp == 8'd0) && (op_b.frac == 23'd0);

    always_comb begin
        sum_next = finite_res;
        if (a_nan || b_nan) begin
            sum_next = QNAN;
        end else if (a_inf && b_inf && (op_a.sign != op_b.sign)) begin
            sum_next = QNAN;
        end else if (a_inf) begin
            sum_next = a;
        end else if (b_inf) begin
            sum_next = b;
        end else if (a_zero && b_zero) begin
            sum_next = {op_a.sign & op_b.sign, 31'd0};
        end else if (a_zero) begin
            sum_next = b;
        end else if (b_zero) begin
            sum_next = a;
        end
    end

    // ---------------- output register ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s <= 32'h0000_0000;
        end else begin
            s <= sum_next;
        end
    end

endmodule

// File: tb/tb_fp_adderz.sv
// tb_fp_adderz: self-checking bench for fp_adderz. Directed vectors with
// known sums plus a randomized exponent sweep checked against an exact
// integer-arithmetic reference of binary32 addition.
module tb_fp_adderz;

    logic        clk;
    logic        rst_n;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] s;

    int checks = 0;
    int errors = 0;

    fp_adderz dut (
        .clk   (clk),
        .rst_n (rst_n),
        .a     (a),
        .b     (b),
        .s     (s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Exact reference: each finite operand is an integer multiple of 2^-149,
    // so the sum is an exact wide integer that is then rounded once.
    function automatic logic [31:0] ref_add(input logic [31:0] x, input logic [31:0] y);
        logic [299:0]        mx;
        logic [299:0]        my;
        logic [299:0]        mag;
        logic [299:0]        keep;
        logic [299:0]        rem;
        logic [299:0]        half;
        logic signed [299:0] v;
        logic                sg;
        int                  p;
        int                  sh;
        int                  e;
        bit xnan = (x[30:23] == 8'hFF) && (x[22:0] != 0);
        bit ynan = (y[30:23] == 8'hFF) && (y[22:0] != 0);
        bit xinf = (x[30:23] == 8'hFF) && (x[22:0] == 0);
        bit yinf = (y[30:23] == 8'hFF) && (y[22:0] == 0);
        bit xz   = (x[30:0] == 0);
        bit yz   = (y[30:0] == 0);
        if (xnan || ynan) return 32'h7FC00000;
        if (xinf && yinf) return (x[31] != y[31]) ? 32'h7FC00000 : x;
        if (xinf) return x;
        if (yinf) return y;
        if (xz && yz) return {x[31] & y[31], 31'd0};
        if (xz) return y;
        if (yz) return x;
        mx = 300'(x[22:0]);
        if (x[30:23] != 0) mx = (mx | (300'(1) << 23)) << (x[30:23] - 1);
        my = 300'(y[22:0]);
        if (y[30:23] != 0) my = (my | (300'(1) << 23)) << (y[30:23] - 1);
        v = (x[31] ? -$signed(mx) : $signed(mx)) + (y[31] ? -$signed(my) : $signed(my));
        if (v == 0) return 32'h00000000;
        sg  = v[299];
        mag = sg ? 300'(-v) : 300'(v);
        p = 0;
        for (int i = 0; i < 300; i++) if (mag[i]) p = i;
        if (p < 23) return {sg, 8'd0, mag[22:0]};
        sh   = p - 23;
        e    = p - 22;
        keep = mag >> sh;
        rem  = mag - (keep << sh);
        if (sh > 0) begin
            half = 300'(1) << (sh - 1);
            if (rem > half || (rem == half && keep[0])) keep = keep + 1;
        end
        if (keep[24]) begin
            keep = keep >> 1;
            e++;
        end
        if (e >= 255) return {sg, 8'hFF, 23'd0};
        return {sg, 8'(e), keep[22:0]};
    endfunction

    task automatic run_op(input logic [31:0] x, input logic [31:0] y,
                          input logic [31:0] expv, input string tag, input bit verbose);
        a = x;
        b = y;
        @(posedge clk);
        #1;
        check_eq(tag, s, expv);
        if (verbose) $display("op %s a=%h b=%h s=%h exp=%h", tag, x, y, s, expv);
    endtask

    localparam int NDIR = 25;
    logic [31:0] dir_tab [0:NDIR-1][0:2] = '{
        '{32'h440d491c, 32'h4d064db7, 32'h4d064dda},
        '{32'h12e1798b, 32'h121f73da, 32'h131899bc},
        '{32'h4d675968, 32'h4ad42cf7, 32'h4d6dfad0},
        '{32'h40000000, 32'h34000000, 32'h40000000},
        '{32'h40000000, 32'h34000001, 32'h40000001},
        '{32'h3fffffff, 32'h34000000, 32'h40000000},
        '{32'h407fffff, 32'h347fffff, 32'h40800000},
        '{32'h407fffff, 32'h34400000, 32'h40800000},
        '{32'h3F800001, 32'hBF800001, 32'h00000000},
        '{32'h3F800001, 32'hBF800000, 32'h34000000},
        '{32'h15ffc7d4, 32'h1f7fabc1, 32'h1f7fabe1},
        '{32'h00012832, 32'h0014283c, 32'h0015506e},
        '{32'h00012832, 32'h8014283c, 32'h8013000a},
        '{32'h00b627be, 32'h000a21a8, 32'h00c04966},
        '{32'h02682174, 32'h826f0850, 32'h803736e0},
        '{32'h00d47943, 32'h80c67efc, 32'h000dfa47},
        '{32'h00004002, 32'h00000002, 32'h00004004},
        '{32'h7F800000, 32'hFF800000, 32'h7FC00000},
        '{32'h7FC00001, 32'h3F800000, 32'h7FC00000},
        '{32'h7F800000, 32'h3F800000, 32'h7F800000},
        '{32'h80000000, 32'h80000000, 32'h80000000},
        '{32'h00000000, 32'h80000000, 32'h00000000},
        '{32'h3F800000, 32'h00000000, 32'h3F800000},
        '{32'h80000000, 32'h80000001, 32'h80000001},
        '{32'h7F7FFFFF, 32'h7F7FFFFF, 32'h7F800000}
    };

    task automatic sweep_op(input int ea, input int eb, input int sgn);
        logic [31:0] x;
        logic [31:0] y;
        x = {sgn[1], 8'(ea), 23'($urandom)};
        y = {sgn[0], 8'(eb), 23'($urandom)};
        run_op(x, y, ref_add(x, y), $sformatf("sweep %h+%h", x, y), 1'b0);
    endtask

    initial begin
        rst_n = 1'b1;
        a     = 32'h3F800000;
        b     = 32'h3F800000;
        #1 rst_n = 1'b0;
        #1 check_eq("reset_initial", s, 32'h00000000);
        repeat (3) @(posedge clk);
        #1 check_eq("reset_hold", s, 32'h00000000);
        rst_n = 1'b1;

        run_op(32'h00000000, 32'h00000000, 32'h00000000, "zero_zero", 1'b1);

        for (int i = 0; i < NDIR; i++) begin
            run_op(dir_tab[i][0], dir_tab[i][1], dir_tab[i][2], $sformatf("dir%0d", i), 1'b1);
            run_op(dir_tab[i][1], dir_tab[i][0], dir_tab[i][2], $sformatf("dir%0d_swap", i), 1'b1);
        end

        // Asynchronous reset in the middle of operation.
        run_op(32'h3F800000, 32'h3F800000, 32'h40000000, "pre_reset", 1'b1);
        #2 rst_n = 1'b0;
        #1 check_eq("reset_async", s, 32'h00000000);
        @(posedge clk);
        #1 check_eq("reset_async_hold", s, 32'h00000000);
        rst_n = 1'b1;
        run_op(32'h00000000, 32'h00000000, 32'h00000000, "zero_after_reset", 1'b1);

        // Exponent sweep: every ea with a rotating third of eb values.
        for (int ea = 0; ea < 255; ea++) begin
            for (int j = 0; j < 85; j++) begin
                sweep_op(ea, 3 * j + ((ea + j) % 3), (ea + j) % 4);
            end
            $display("sweep row ea=%0d checks=%0d", ea, checks);
        end
        // Near-equal exponents with every sign combination: cancellation.
        for (int ea = 0; ea < 255; ea++) begin
            for (int d = -2; d <= 2; d++) begin
                if (ea + d >= 0 && ea + d <= 254) begin
                    for (int sg = 0; sg < 4; sg++) sweep_op(ea, ea + d, sg);
                end
            end
        end
        $display("near-exponent sweep done checks=%0d", checks);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
